// File: rtl/booth_seq_mult_r4_pkg.sv
// Shared types and helpers for the radix-4 Booth multipliers: FSM states,
// the {neg, one, two} digit encoding, the window decoder and the digit count.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic neg;
        logic one;
        logic two;
    } booth_digit_t;

    function automatic int booth_digits(input int n);
        return n / 2 + 1;
    endfunction

    // 000/111 -> 0, 001/010 -> +1, 011 -> +2, 100 -> -2, 101/110 -> -1
    function automatic booth_digit_t booth_decode(input logic [2:0] w);
        booth_digit_t d;
        d.neg = w[2] & ~(w[1] & w[0]);
        d.one = w[1] ^ w[0];
        d.two = (w == 3'b011) || (w == 3'b100);
        return d;
    endfunction

endpackage

// File: rtl/booth_seq_mult_r4_pp_gen.sv
// Combinational radix-4 Booth partial-product generator: one 3-bit window
// times the (N+1)-bit extended multiplicand, giving a signed (N+2)-bit result.
module booth_pp_gen
    import booth_pkg::*;
#(
    parameter int N = 16
) (
    input  logic [2:0]        window,
    input  logic [N:0]        mde,
    output logic signed [N+1:0] pp
);

    booth_digit_t dig;
    logic [N+1:0] mag;

    assign dig = booth_decode(window);

    // mag is either mde sign-extended by one bit (x1) or mde shifted left (x2)
    genvar gi;
    generate
        for (gi = 0; gi < N + 2; gi++) begin : g_mag
            if (gi == 0) begin : g_lsb
                assign mag[gi] = dig.one & mde[0];
            end else if (gi == N + 1) begin : g_msb
                assign mag[gi] = (dig.one | dig.two) & mde[N];
            end else begin : g_mid
                assign mag[gi] = (dig.one & mde[gi]) | (dig.two & mde[gi-1]);
            end
        end
    endgenerate

    assign pp = dig.neg ? (~mag + 1'b1) : mag;

endmodule

// File: rtl/booth_seq_mult_r4.sv
// Sequential radix-4 Booth multiplier, one digit per clock, start/busy/done.
// Define BOOTH_EARLY_TERM_EN to finish as soon as all remaining digits are zero.
module booth_seq_mult_r4
    import booth_pkg::*;
#(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           is_signed,
    input  logic [N-1:0]   md,
    input  logic [N-1:0]   mr,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] out
);

    localparam int D  = booth_digits(N);
    localparam int CW = $clog2(D + 1);

    state_t         state_reg, state_next;
    logic           busy_reg, busy_next;
    logic           done_reg, done_next;
    logic [N+2:0]   sr_reg;
    logic [N:0]     mde_reg;
    logic [2*N-1:0] acc_reg;
    logic [2*N-1:0] out_reg;
    logic [CW-1:0]  cnt_reg;

    logic           accept;
    logic           early_exit;
    logic           last_digit;
    logic [N+1:0]   pp;
    logic [2*N-1:0] pp_ext;
    logic [2*N-1:0] acc_sum;
    logic [N+2:0]   sr_shift;

    booth_pp_gen #(.N(N)) u_pp_gen (
        .window (sr_reg[2:0]),
        .mde    (mde_reg),
        .pp     (pp)
    );

    assign accept   = start && (state_reg == IDLE || state_reg == DONE);
    assign pp_ext   = {{(N-2){pp[N+1]}}, pp};
    assign acc_sum  = acc_reg + (pp_ext << {cnt_reg, 1'b0});
    assign sr_shift = {{2{sr_reg[N+2]}}, sr_reg[N+2:2]};

    // A shifted sr of all 0s or all 1s yields only zero digits from here on
`ifdef BOOTH_EARLY_TERM_EN
    assign early_exit = (sr_shift == '0) || (sr_shift == '1);
`else
    assign early_exit = 1'b0;
`endif

    assign last_digit = (cnt_reg == CW'(D - 1)) || early_exit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = RUN;
            RUN:     if (last_digit) state_next = DONE;
            DONE:    state_next = accept ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Flags are registered from the next state so they align with state_reg
    always_comb begin
        busy_next = (state_next == RUN);
        done_next = (state_next == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_reg  <= '0;
            mde_reg <= '0;
            acc_reg <= '0;
            cnt_reg <= '0;
            out_reg <= '0;
        end else if (accept) begin
            sr_reg  <= {{2{is_signed & mr[N-1]}}, mr, 1'b0};
            mde_reg <= {is_signed & md[N-1], md};
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (state_reg == RUN) begin
            acc_reg <= acc_sum;
            sr_reg  <= sr_shift;
            cnt_reg <= cnt_reg + 1'b1;
            if (last_digit) begin
                out_reg <= acc_sum;
            end
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign out  = out_reg;

endmodule

// File: tb/tb_booth_seq_mult_r4.sv
// Self-checking bench for booth_seq_mult_r4 (N=16): directed vectors, handshake
// corner cases and randomized back-to-back products against an arithmetic model.
module tb_booth_seq_mult_r4;

    localparam int N = 16;
    localparam int D = N / 2 + 1;
    localparam int M = 1500;

    logic           clk = 1'b0;
    logic           reset;
    logic           start;
    logic           is_signed;
    logic [N-1:0]   md;
    logic [N-1:0]   mr;
    logic           busy;
    logic           done;
    logic [2*N-1:0] out;

    int checks = 0;
    int errors = 0;

    logic           s_arr [M];
    logic [N-1:0]   a_arr [M];
    logic [N-1:0]   b_arr [M];

    booth_seq_mult_r4 #(.N(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .md        (md),
        .mr        (mr),
        .busy      (busy),
        .done      (done),
        .out       (out)
    );

    always #5 clk = ~clk;

    function automatic logic [2*N-1:0] ref_product(input logic s, input logic [N-1:0] a,
                                                   input logic [N-1:0] b);
        logic [2*N-1:0] ax, bx;
        ax = s ? {{N{a[N-1]}}, a} : {{N{1'b0}}, a};
        bx = s ? {{N{b[N-1]}}, b} : {{N{1'b0}}, b};
        return ax * bx;
    endfunction

    // Cycles from the accepting edge to done: D, or with early termination the
    // first digit after which the remaining multiplier value is 0 or -1.
    function automatic int ref_latency(input logic s, input logic [N-1:0] b);
`ifdef BOOTH_EARLY_TERM_EN
        logic signed [N+4:0] x, y;
        x = {{4{s & b[N-1]}}, b, 1'b0};
        for (int k = 1; k < D; k++) begin
            y = x >>> (2 * k);
            if (y == '0 || y == '1) return k;
        end
        return D;
`else
        return (s || !s) ? D : D;
`endif
    endfunction

    function automatic logic [N-1:0] pick();
        logic [N-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b1, {(N-1){1'b0}}};
            3:       v = {1'b0, {(N-1){1'b1}}};
            default: v = N'($urandom);
        endcase
        return v;
    endfunction

    task automatic wait_done(output int lat);
        lat = 0;
        forever begin
            @(posedge clk); #1;
            lat++;
            checks++;
            if (busy === 1'b1 && done === 1'b1) begin
                errors++;
                $display("FAIL busy_done_overlap at cycle %0d: busy=%b done=%b required not both high",
                         lat, busy, done);
            end
            if (done === 1'b1) break;
            if (lat > 4 * D) begin
                errors++;
                $display("FAIL done_timeout: no done after %0d cycles", lat);
                break;
            end
        end
    endtask

    task automatic do_op(input logic s, input logic [N-1:0] a, input logic [N-1:0] b,
                         output logic [2*N-1:0] res, output int lat);
        is_signed = s; md = a; mr = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        md = N'($urandom); mr = N'($urandom); is_signed = ~s;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_rise: busy=%b required 1", busy);
        end
        wait_done(lat);
        res = out;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; is_signed = 1'b0; md = '0; mr = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== '0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b out=%h required 0 0 0", busy, done, out);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic           s_t [3] = '{1'b1, 1'b0, 1'b1};
        logic [N-1:0]   a_t [3] = '{16'h0003, 16'hFFFF, 16'h8000};
        logic [N-1:0]   b_t [3] = '{16'hFFFB, 16'hFFFF, 16'h8000};
        logic [2*N-1:0] e_t [3] = '{32'hFFFFFFF1, 32'hFFFE0001, 32'h40000000};
        logic [2*N-1:0] res;
        int lat;
        for (int i = 0; i < 3; i++) begin
            do_op(s_t[i], a_t[i], b_t[i], res, lat);
            $display("basic s=%0d md=%h mr=%h out=%h lat=%0d", s_t[i], a_t[i], b_t[i], res, lat);
            checks++;
            if (res !== e_t[i]) begin
                errors++;
                $display("FAIL basic_product %0d: got %h required %h", i, res, e_t[i]);
            end
            checks++;
            if (lat !== ref_latency(s_t[i], b_t[i])) begin
                errors++;
                $display("FAIL basic_latency %0d: got %0d required %0d", i, lat,
                         ref_latency(s_t[i], b_t[i]));
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0) begin
                errors++;
                $display("FAIL done_width %0d: done=%b required 0", i, done);
            end
        end
    endtask

    task automatic test_busy_ignore();
        logic [2*N-1:0] exp_p;
        int lat, extra;
        exp_p = ref_product(1'b0, 16'h1234, 16'h5A5A);
        is_signed = 1'b0; md = 16'h1234; mr = 16'h5A5A; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        is_signed = 1'b1; md = 16'hFFFF; mr = 16'hFFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        lat += 3;
        $display("busy_ignore out=%h lat=%0d", out, lat);
        checks++;
        if (out !== exp_p) begin
            errors++;
            $display("FAIL busy_ignore_product: got %h required %h", out, exp_p);
        end
        checks++;
        if (lat !== ref_latency(1'b0, 16'h5A5A)) begin
            errors++;
            $display("FAIL busy_ignore_latency: got %0d required %0d", lat,
                     ref_latency(1'b0, 16'h5A5A));
        end
        extra = 0;
        repeat (D + 2) begin
            @(posedge clk); #1;
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL busy_ignore_extra: %0d cycles of busy/done required 0", extra);
        end
    endtask

    task automatic test_mid_reset();
        logic [2*N-1:0] res;
        int lat;
        do_op(1'b1, 16'h0123, 16'h4567, res, lat);
        checks++;
        if (res !== ref_product(1'b1, 16'h0123, 16'h4567)) begin
            errors++;
            $display("FAIL pre_reset_product: got %h required %h", res,
                     ref_product(1'b1, 16'h0123, 16'h4567));
        end
        is_signed = 1'b0; md = 16'hABCD; mr = 16'h5A5A; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        $display("mid_reset busy=%b done=%b out=%h", busy, done, out);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out !== '0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b done=%b out=%h required 0 0 0", busy, done, out);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        do_op(1'b1, 16'h7FFF, 16'h8001, res, lat);
        $display("post_reset out=%h lat=%0d", res, lat);
        checks++;
        if (res !== ref_product(1'b1, 16'h7FFF, 16'h8001) || lat !== ref_latency(1'b1, 16'h8001)) begin
            errors++;
            $display("FAIL post_reset_op: got %h/%0d required %h/%0d", res, lat,
                     ref_product(1'b1, 16'h7FFF, 16'h8001), ref_latency(1'b1, 16'h8001));
        end
    endtask

    task automatic test_early_term();
        logic [N-1:0]   b_t [2] = '{16'h0001, 16'hFFFF};
        logic [2*N-1:0] e_t [2] = '{32'h00000007, 32'hFFFFFFF9};
        logic [2*N-1:0] res;
        int lat;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            do_op(1'b1, 16'h0007, b_t[i], res, lat);
            $display("early_term md=0007 mr=%h out=%h lat=%0d", b_t[i], res, lat);
            checks++;
            if (res !== e_t[i]) begin
                errors++;
                $display("FAIL early_product %0d: got %h required %h", i, res, e_t[i]);
            end
            checks++;
            if (lat !== ref_latency(1'b1, b_t[i])) begin
                errors++;
                $display("FAIL early_latency %0d: got %0d required %0d", i, lat,
                         ref_latency(1'b1, b_t[i]));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2*N-1:0] exp_p;
        int lat;
        for (int i = 0; i < M; i++) begin
            s_arr[i] = 1'($urandom);
            a_arr[i] = pick();
            b_arr[i] = pick();
        end
        @(posedge clk); #1;
        is_signed = s_arr[0]; md = a_arr[0]; mr = b_arr[0]; start = 1'b1;
        @(posedge clk); #1;
        is_signed = s_arr[1]; md = a_arr[1]; mr = b_arr[1];
        for (int i = 0; i < M; i++) begin
            wait_done(lat);
            exp_p = ref_product(s_arr[i], a_arr[i], b_arr[i]);
            $display("b2b %0d s=%0d md=%h mr=%h out=%h lat=%0d", i, s_arr[i], a_arr[i],
                     b_arr[i], out, lat);
            checks++;
            if (out !== exp_p) begin
                errors++;
                $display("FAIL b2b_product %0d: got %h required %h", i, out, exp_p);
            end
            checks++;
            if (lat !== ref_latency(s_arr[i], b_arr[i])) begin
                errors++;
                $display("FAIL b2b_latency %0d: got %0d required %0d", i, lat,
                         ref_latency(s_arr[i], b_arr[i]));
            end
            if (i + 1 < M) begin
                @(posedge clk); #1;
                checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_restart %0d: busy=%b done=%b required 1 0", i, busy, done);
                end
                if (i + 2 < M) begin
                    is_signed = s_arr[i+2]; md = a_arr[i+2]; mr = b_arr[i+2];
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_busy_ignore();
        test_mid_reset();
        test_early_term();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
